// File: rtl/mem_ctrl.sv
// Memory access controller: latches a CPU request into MAR/MDR and issues one single-cycle RAM strobe.
// Optional range check (err output, no strobe beyond MEM_WORDS) is enabled by defining MEM_RANGE_CHECK_EN.
module mem_ctrl #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned MEM_WORDS   = 512,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_read,
    output logic              ram_write
`ifdef MEM_RANGE_CHECK_EN
    ,
    output logic              err
`endif
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              busy_d, done_d, ram_read_d, ram_write_d;
    logic              strobe_en;

`ifdef MEM_RANGE_CHECK_EN
    logic oob_q, oob_d;
    logic err_d;
    assign strobe_en = ~oob_q;
`else
    assign strobe_en = 1'b1;
`endif

    // Next-state, datapath loads and next values of the registered outputs
    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
`ifdef MEM_RANGE_CHECK_EN
        oob_d   = oob_q;
        err_d   = err;
`endif
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    mar_d   = addr;
                    we_d    = we;
                    state_d = SETUP;
                    if (we) begin
                        mdr_d = wr_data;
                    end
`ifdef MEM_RANGE_CHECK_EN
                    oob_d = (32'(addr) >= 32'(MEM_WORDS));
                    err_d = 1'b0;
`endif
                end
            end
            SETUP:  state_d = STROBE;
            STROBE: begin
                cnt_d   = CNT_W'(WAIT_CYCLES);
                state_d = HOLD;
            end
            HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // RAM output is valid from the edge after the strobe onward
                    if (!we_q && strobe_en) begin
                        mdr_d = ram_data_out;
                    end
`ifdef MEM_RANGE_CHECK_EN
                    err_d = oob_q;
`endif
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        ram_read_d  = (state_d == STROBE) && !we_d && strobe_en;
        ram_write_d = (state_d == STROBE) &&  we_d && strobe_en;
    end

    // State, MAR/MDR and registered outputs
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= IDLE;
            mar_q     <= '0;
            mdr_q     <= '0;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ram_read  <= 1'b0;
            ram_write <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
            oob_q     <= 1'b0;
            err       <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mar_q     <= mar_d;
            mdr_q     <= mdr_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            busy      <= busy_d;
            done      <= done_d;
            ram_read  <= ram_read_d;
            ram_write <= ram_write_d;
`ifdef MEM_RANGE_CHECK_EN
            oob_q     <= oob_d;
            err       <= err_d;
`endif
        end
    end

    assign rd_data     = mdr_q;
    assign ram_address = mar_q;
    assign ram_data_in = mdr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: random requests against a word-array reference model,
// with a behavioural edge-triggered RAM and a monitor that checks strobes and done pulses.
`timescale 1ns/1ps
module tb_mem_ctrl;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned WAIT   = 2;
    localparam int unsigned LAT    = 3 + WAIT;   // accept edge to done cycle
    localparam int unsigned PERIOD = 5 + WAIT;   // accept edge to next accept edge

    logic              clk = 1'b0;
    logic              clr_n = 1'b0;
    logic              req = 1'b0;
    logic              we = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [DATA_W-1:0] ram_data_out = '0;
    logic              busy, done, ram_read, ram_write;
    logic [DATA_W-1:0] rd_data, ram_data_in;
    logic [ADDR_W-1:0] ram_address;
`ifdef MEM_RANGE_CHECK_EN
    logic              err;
`endif

    mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_WORDS(512), .WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .clr_n(clr_n), .req(req), .we(we), .addr(addr), .wr_data(wr_data),
        .ram_data_out(ram_data_out), .busy(busy), .done(done), .rd_data(rd_data),
        .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_read(ram_read), .ram_write(ram_write)
`ifdef MEM_RANGE_CHECK_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] init_val(input int i);
        return (i == 'h0A0) ? 32'h1234_5678 : (32'hC0DE_0000 | 32'(i));
    endfunction

    // Edge-triggered word RAM
    logic [DATA_W-1:0] ram [512];
    logic              ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 512; i++) ram[i] <= init_val(i);
            ram_init <= 1'b1;
        end else begin
            if (ram_write) ram[ram_address] <= ram_data_in;
            if (ram_read)  ram_data_out <= ram[ram_address];
        end
    end

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rd;
        int                done_cyc;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] ref_mem [512];
    int                n_checks = 0;
    int                n_fail = 0;
    int                n_issued = 0;
    int                n_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: strobe rules every cycle, full comparison on each done pulse
    int                n_strobe = 0;
    int                s_cyc = 0;
    logic              prev_strobe = 1'b0;
    logic              s_we = 1'b0;
    logic [ADDR_W-1:0] s_addr = '0;
    logic [DATA_W-1:0] s_data = '0;
    always @(negedge clk) begin
        if (!clr_n) begin
            n_strobe    = 0;
            prev_strobe = 1'b0;
        end else begin
            if (ram_read || ram_write) begin
                check("strobe_exclusive", 64'(ram_read & ram_write), 64'd0);
                check("strobe_one_cycle", 64'(prev_strobe), 64'd0);
                n_strobe++;
                s_cyc  = cyc;
                s_we   = ram_write;
                s_addr = ram_address;
                s_data = ram_data_in;
            end
            prev_strobe = ram_read | ram_write;
            if (done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 64'(done), 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("done_cycle", 64'(cyc), 64'(e.done_cyc));
                    check("strobe_count", 64'(n_strobe), 64'd1);
                    check("strobe_cycle", 64'(s_cyc), 64'(e.done_cyc - int'(LAT) + 1));
                    check("strobe_type_we", 64'(s_we), 64'(e.we));
                    check("strobe_addr", 64'(s_addr), 64'(e.addr));
                    if (e.we) check("strobe_wdata", 64'(s_data), 64'(e.wdata));
                    check("rd_data", 64'(rd_data), 64'(e.rd));
                    check("busy_at_done", 64'(busy), 64'd1);
`ifdef MEM_RANGE_CHECK_EN
                    check("err_at_done", 64'(err), 64'd0);
`endif
                end
                n_strobe = 0;
            end
        end
    end

    // One transaction: optional idle gap, accept edge, then the busy window.
    // hold keeps req high through the busy window; poke_at>=0 drives a conflicting req once.
    task automatic do_txn(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input int gap, input logic hold, input int poke_at);
        exp_t e;
        if (gap > 0) begin
            req = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        req = 1'b1; we = w; addr = a; wr_data = d;
        @(posedge clk);
        #1;
        e.we = w; e.addr = a; e.wdata = d; e.done_cyc = cyc + int'(LAT);
        if (w) begin
            ref_mem[a] = d;
            e.rd = d;
        end else begin
            e.rd = ref_mem[a];
        end
        exp_q.push_back(e);
        n_issued++;
        for (int k = 0; k < int'(PERIOD) - 1; k++) begin
            if (k == poke_at) begin
                req = 1'b1; we = $urandom_range(0, 1) == 1; addr = a ^ ADDR_W'(3); wr_data = $urandom;
            end else begin
                req = hold;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        check("rst_ram_address", 64'(ram_address), 64'd0);
        check("rst_strobes", 64'({ram_read, ram_write}), 64'd0);
        clr_n = 1'b1;

        // Write then read back the same word
        do_txn(1'b1, 9'h005, 32'hDEAD_BEEF, 1, 1'b0, -1);
        do_txn(1'b0, 9'h005, 32'h0, 0, 1'b0, -1);
        // Preloaded word
        do_txn(1'b0, 9'h0A0, 32'h0, 1, 1'b0, -1);
        // Conflicting request two cycles after acceptance is dropped
        do_txn(1'b0, 9'h001, 32'h0, 2, 1'b0, 1);
        // req held high, alternating addresses
        for (int i = 0; i < 6; i++)
            do_txn(($urandom_range(0, 1) == 1), (i % 2 == 0) ? 9'h003 : 9'h004, $urandom, 0, 1'b1, -1);

        // Reset in the middle of a write strobe to 0x010
        req = 1'b0;
        @(posedge clk);
        #1;
        req = 1'b1; we = 1'b1; addr = 9'h010; wr_data = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #2;
        check("pre_rst_ram_write", 64'(ram_write), 64'd1);
        clr_n = 1'b0;
        #1;
        check("async_rst_ram_write", 64'(ram_write), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_rd_data", 64'(rd_data), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        clr_n = 1'b1;
        do_txn(1'b0, 9'h010, 32'h0, 1, 1'b0, -1);

        // Random traffic over a small address set
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 9'h0A0 : ADDR_W'($urandom_range(0, 15));
            do_txn(($urandom_range(0, 1) == 1), a, $urandom, $urandom_range(0, 2),
                   ($urandom_range(0, 3) == 0), $urandom_range(0, 5) - 1);
        end

        req = 1'b0;
        repeat (PERIOD + 3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("done_count", 64'(n_done), 64'(n_issued));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory access controller between the CPU datapath/control unit and the edge-triggered word RAM.
- Latches a request into internal MAR/MDR registers and presents stable address/data to the RAM.
- Issues exactly one single-cycle read or write strobe, captures read data back into MDR, and signals completion with a one-cycle done pulse.
- Isolates the clocked CPU from the RAM's strobe-edge timing.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 9, word address width (512-word RAM).
- MEM_WORDS, 512, number of implemented words; used only by the optional range check.
- WAIT_CYCLES, 0, extra HOLD cycles after the strobe before read data is captured (0 to 15).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clr_n  in  1  asynchronous active-low reset.
- req  in  1  request strobe from the control unit; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  ADDR_W  word address; sampled with req.
- wr_data  in  DATA_W  write data; sampled with req.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- rd_data  out  DATA_W  MDR contents; valid when done=1 for a read.
- ram_address  out  ADDR_W  registered MAR driven to the RAM.
- ram_data_in  out  DATA_W  registered MDR driven to the RAM.
- ram_read  out  1  registered read strobe to the RAM.
- ram_write  out  1  registered write strobe to the RAM.
- err  out  1  range-error flag; exists only with MEM_RANGE_CHECK_EN.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clr_n).
- Reset values:
  - All outputs 0.
  - MAR and MDR are 0.
  - The state register goes to IDLE.
  - If reset asserts mid-transaction, the strobes drop to 0 immediately, no done pulse is produced, and the transaction is abandoned.
- States: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE:
  - If req=1: load MAR<=addr, MDR<=wr_data (write only; on a read MDR is unchanged), latch we, and go to SETUP.
  - Otherwise stay in IDLE.
- SETUP: MAR/MDR drive the RAM, both strobes are 0; go to STROBE unconditionally. This gives the RAM one full cycle of address/data setup.
- STROBE:
  - Exactly one of ram_write / ram_read is high for exactly this one cycle, selected by the latched we.
  - Load the wait counter with WAIT_CYCLES; go to HOLD.
- HOLD:
  - Both strobes are 0; MAR/MDR are held.
  - While the counter is nonzero, decrement it and stay.
  - When the counter is 0: on a read, MDR<=ram_data_out; go to DONE.
- DONE: done=1 for one cycle and busy=1; rd_data=MDR. Go to IDLE. A req in this cycle is ignored.
- Latency: req sampled at edge 0 gives done high in the cycle after edge 3+WAIT_CYCLES, i.e. 4+WAIT_CYCLES cycles request-to-done. The next request is accepted at the edge that leaves DONE+1, i.e. one request per 5+WAIT_CYCLES cycles maximum.
- req while busy=1 is ignored; it is not queued. The control unit must hold or reassert req after done.
- rd_data keeps the last MDR value between transactions. After a write it shows the written data.
- ram_read and ram_write are never high simultaneously and never high for more than one consecutive cycle.
- Address wrap: none; addr is used as-is within ADDR_W.

Optional Feature:
- MEM_RANGE_CHECK_EN defined:
  - In IDLE, a req with addr >= MEM_WORDS still follows SETUP/STROBE/HOLD/DONE timing, but no strobe is issued.
  - err=1 together with done; MDR is unchanged on such a read.
  - err clears on the next accepted req or on reset.
- MEM_RANGE_CHECK_EN not defined: the err port and comparator are absent, and every address is strobed.

Test Plan:
- Reset: clr_n=0 mid-STROBE of a write to 0x010 -> ram_write drops to 0 without waiting for clk, state is IDLE, done is never pulsed, RAM[0x010] is unchanged if the strobe had not yet risen.
- Write/read: write 0xDEADBEEF to 0x005, then read 0x005 with WAIT_CYCLES=0 -> ram_write high exactly one cycle, done 4 cycles after each req, rd_data=0xDEADBEEF on the read's done.
- WAIT_CYCLES=3: read of 0x0A0 preloaded with 0x12345678 -> done 7 cycles after req; ram_read high 1 cycle only; rd_data=0x12345678.
- Busy rejection: req pulsed again 2 cycles after an accepted read of 0x001 with addr=0x002 -> only one ram_read pulse (address 0x001), one done.
- Back-to-back: req held high continuously with alternating addresses 0x003/0x004 -> a new transaction starts in the cycle after each DONE; strobes are never simultaneous; done pulses are 5 cycles apart.
- MEM_RANGE_CHECK_EN, MEM_WORDS=256: read of 0x1FF -> no ram_read pulse, err=1 with done, rd_data unchanged; the next valid req clears err.
